fetch_pc_unit: RTL and testbench

//  Instruction-fetch stage of the 16-bit pipelined CPU. Holds the PC, drives instruction memory,
//  and loads the IF/ID pipeline register. Consumes the redirect outputs of the EX-stage branch

---
 rtl/fetch_pc_unit.sv | 127 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF stage: PC register, instruction memory drive and IF/ID register
// Redirects from EX squash wrong-path fetches; HALT freezes fetch until a redirect or reset.
module fetch_pc_unit #(
  parameter int                 PC_W          = 16,
  parameter int                 INSTR_W       = 16,
  parameter logic [PC_W-1:0]    RESET_PC      = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR     = 16'h0000,
  parameter logic [3:0]         HALT_OPCODE   = 4'hF,
  parameter int                 SQUASH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch2_idex,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               putPCback,
  input  logic [PC_W-1:0]    execPCadded,
  input  logic               stall,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_ifid,
  output logic [PC_W-1:0]    pc_added_ifid,
  output logic               valid_ifid,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_SQUASH = 2'd1,
    S_HALT   = 2'd2
  } state_t;

  localparam logic [2:0] SQ_INIT = 3'(SQUASH_CYCLES - 1);

  state_t             state_q, state_d;
  logic [2:0]         sq_cnt_q, sq_cnt_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_added_q, pc_added_d;
  logic               valid_q, valid_d;

  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    pc_inc;
  logic               fetch_is_halt;

  // putPCback outranks branch2_idex when both fire on the same edge
  assign redirect      = putPCback | branch2_idex;
  assign redirect_pc   = putPCback ? execPCadded : branch_target;
  assign pc_inc        = pc_q + PC_W'(1);
  assign fetch_is_halt = (imem_data[INSTR_W-1 -: 4] == HALT_OPCODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      sq_cnt_q   <= 3'd0;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_added_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sq_cnt_q   <= sq_cnt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_added_q <= pc_added_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    if (redirect) begin
      state_d  = S_SQUASH;
      sq_cnt_d = SQ_INIT;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!stall && fetch_is_halt) state_d = S_HALT;
        end
        S_SQUASH: begin
          if (sq_cnt_q == 3'd0) state_d = S_RUN;
          else                  sq_cnt_d = sq_cnt_q - 3'd1;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_RUN;
      endcase
    end
  end

  // Datapath next-state: pc and IF/ID register contents
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_added_d = pc_added_q;
    valid_d    = valid_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!stall) begin
            instr_d    = imem_data;
            pc_added_d = pc_inc;
            valid_d    = 1'b1;
            pc_d       = pc_inc;
          end
        end
        default: begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    imem_addr     = pc_q;
    instr_ifid    = instr_q;
    pc_added_ifid = pc_added_q;
    valid_ifid    = valid_q;
    halted        = (state_q == S_HALT);
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed vectors, HALT/reset sequences and randomized model check
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch2_idex = 1'b0;
  logic [15:0] branch_target = '0;
  logic        putPCback = 1'b0;
  logic [15:0] execPCadded = '0;
  logic        stall = 1'b0;

  logic [15:0] imem_addr0, imem_data0, instr0, padd0;
  logic        valid0, halted0;
  logic [15:0] imem_addr1, imem_data1, instr1, padd1;
  logic        valid1, halted1;

  logic [15:0] imem [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_data0 = imem[imem_addr0[7:0]];
  assign imem_data1 = imem[imem_addr1[7:0]];

  fetch_pc_unit dut0 (
    .clk(clk), .rst(rst), .branch2_idex(branch2_idex), .branch_target(branch_target),
    .putPCback(putPCback), .execPCadded(execPCadded), .stall(stall),
    .imem_addr(imem_addr0), .imem_data(imem_data0), .instr_ifid(instr0),
    .pc_added_ifid(padd0), .valid_ifid(valid0), .halted(halted0)
  );

  fetch_pc_unit #(.RESET_PC(16'hFFFF), .SQUASH_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .branch2_idex(branch2_idex), .branch_target(branch_target),
    .putPCback(putPCback), .execPCadded(execPCadded), .stall(stall),
    .imem_addr(imem_addr1), .imem_data(imem_data1), .instr_ifid(instr1),
    .pc_added_ifid(padd1), .valid_ifid(valid1), .halted(halted1)
  );

  // Reference model: bubbles_left counts the NOP edges still owed after a redirect
  localparam int          SQ_N [2]   = '{1, 3};
  localparam logic [15:0] RST_PC [2] = '{16'h0000, 16'hFFFF};
  logic [15:0] m_pc [2];
  logic [15:0] m_instr [2];
  logic [15:0] m_padd [2];
  logic        m_valid [2];
  logic        m_halt [2];
  int          m_bub [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = RST_PC[k]; m_instr[k] = 16'h0; m_padd[k] = 16'h0;
      m_valid[k] = 1'b0; m_halt[k] = 1'b0; m_bub[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (putPCback || branch2_idex) begin
        m_pc[k] = putPCback ? execPCadded : branch_target;
        m_instr[k] = 16'h0; m_valid[k] = 1'b0; m_halt[k] = 1'b0; m_bub[k] = SQ_N[k];
      end else if (m_halt[k]) begin
        m_instr[k] = 16'h0; m_valid[k] = 1'b0;
      end else if (m_bub[k] > 0) begin
        m_bub[k] = m_bub[k] - 1;
        m_instr[k] = 16'h0; m_valid[k] = 1'b0;
      end else if (!stall) begin
        m_instr[k] = imem[m_pc[k][7:0]];
        m_padd[k] = m_pc[k] + 16'd1;
        m_valid[k] = 1'b1;
        m_pc[k] = m_padd[k];
        if (m_instr[k][15:12] == 4'hF) m_halt[k] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic br, input logic [15:0] tgt, input logic pb,
                     input logic [15:0] epc, input logic st);
    branch2_idex = br; branch_target = tgt; putPCback = pb; execPCadded = epc; stall = st;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    branch2_idex = 0; putPCback = 0; stall = 0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        br;
    logic [15:0] tgt;
    logic        pb;
    logic [15:0] epc;
    logic        st;
    logic [15:0] e_instr;
    logic [15:0] e_padd;
    logic        e_valid;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(logic br, logic [15:0] tgt, logic pb, logic [15:0] epc, logic st,
                              logic [15:0] ei, logic [15:0] ep, logic ev, logic [15:0] epcq);
    vec_t v;
    v.br = br; v.tgt = tgt; v.pb = pb; v.epc = epc; v.st = st;
    v.e_instr = ei; v.e_padd = ep; v.e_valid = ev; v.e_pc = epcq;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h1000 | 16'(i);
    imem[7] = 16'hF000;

    vecs[0]  = mk(0, 16'h0,  0, 16'h0,  0, 16'h1000, 16'h1,  1, 16'h1);
    vecs[1]  = mk(0, 16'h0,  0, 16'h0,  0, 16'h1001, 16'h2,  1, 16'h2);
    vecs[2]  = mk(0, 16'h0,  0, 16'h0,  1, 16'h1001, 16'h2,  1, 16'h2);
    vecs[3]  = mk(0, 16'h0,  0, 16'h0,  1, 16'h1001, 16'h2,  1, 16'h2);
    vecs[4]  = mk(0, 16'h0,  0, 16'h0,  0, 16'h1002, 16'h3,  1, 16'h3);
    vecs[5]  = mk(0, 16'h0,  0, 16'h0,  0, 16'h1003, 16'h4,  1, 16'h4);
    vecs[6]  = mk(0, 16'h0,  0, 16'h0,  0, 16'h1004, 16'h5,  1, 16'h5);
    vecs[7]  = mk(1, 16'h40, 0, 16'h0,  0, 16'h0000, 16'h5,  0, 16'h40);
    vecs[8]  = mk(0, 16'h0,  0, 16'h0,  0, 16'h0000, 16'h5,  0, 16'h40);
    vecs[9]  = mk(0, 16'h0,  0, 16'h0,  0, 16'h1040, 16'h41, 1, 16'h41);
    vecs[10] = mk(1, 16'h80, 1, 16'h10, 0, 16'h0000, 16'h41, 0, 16'h10);
    vecs[11] = mk(0, 16'h0,  0, 16'h0,  1, 16'h0000, 16'h41, 0, 16'h10);
    vecs[12] = mk(0, 16'h0,  0, 16'h0,  0, 16'h1010, 16'h11, 1, 16'h11);
    vecs[13] = mk(1, 16'h20, 0, 16'h0,  1, 16'h0000, 16'h11, 0, 16'h20);

    // Reset values
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_instr", 32'(instr0), 32'h0);
    chk("rst_padd", 32'(padd0), 32'h0);
    chk("rst_valid", 32'(valid0), 32'h0);
    chk("rst_halted", 32'(halted0), 32'h0);
    chk("rst_pc", 32'(imem_addr0), 32'h0);
    chk("rst_pc_ffff", 32'(imem_addr1), 32'hFFFF);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].br, vecs[i].tgt, vecs[i].pb, vecs[i].epc, vecs[i].st);
      chk($sformatf("vec%0d_instr", i), 32'(instr0), 32'(vecs[i].e_instr));
      chk($sformatf("vec%0d_padd", i), 32'(padd0), 32'(vecs[i].e_padd));
      chk($sformatf("vec%0d_valid", i), 32'(valid0), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_pc", i), 32'(imem_addr0), 32'(vecs[i].e_pc));
      chk($sformatf("vec%0d_halted", i), 32'(halted0), 32'h0);
    end

    // HALT fetched at 7, frozen, then released by a redirect to 3
    cyc(1, 16'h5, 0, 16'h0, 0);
    cyc(0, 16'h0, 0, 16'h0, 0);
    cyc(0, 16'h0, 0, 16'h0, 0);
    chk("pre_halt_padd", 32'(padd0), 32'h6);
    cyc(0, 16'h0, 0, 16'h0, 0);
    cyc(0, 16'h0, 0, 16'h0, 0);
    chk("halt_instr", 32'(instr0), 32'hF000);
    chk("halt_valid", 32'(valid0), 32'h1);
    chk("halt_flag", 32'(halted0), 32'h1);
    chk("halt_pc", 32'(imem_addr0), 32'h8);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 16'h0, 0, 16'h0, logic'(i[0]));
      chk("halt_hold_flag", 32'(halted0), 32'h1);
      chk("halt_hold_valid", 32'(valid0), 32'h0);
      chk("halt_hold_pc", 32'(imem_addr0), 32'h8);
    end
    cyc(1, 16'h3, 0, 16'h0, 0);
    chk("unhalt_flag", 32'(halted0), 32'h0);
    chk("unhalt_pc", 32'(imem_addr0), 32'h3);
    cyc(0, 16'h0, 0, 16'h0, 0);
    chk("unhalt_squash_valid", 32'(valid0), 32'h0);
    cyc(0, 16'h0, 0, 16'h0, 0);
    chk("unhalt_instr", 32'(instr0), 32'h1003);
    chk("unhalt_padd", 32'(padd0), 32'h4);

    // RESET_PC wrap, 3-cycle squash, and asynchronous reset mid-squash
    do_reset();
    cyc(0, 16'h0, 0, 16'h0, 0);
    chk("wrap_instr", 32'(instr1), 32'h10FF);
    chk("wrap_padd", 32'(padd1), 32'h0);
    chk("wrap_pc", 32'(imem_addr1), 32'h0);
    cyc(1, 16'h30, 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0, 0, 16'h0, 0);
      chk("sq3_valid", 32'(valid1), 32'h0);
      chk("sq3_instr", 32'(instr1), 32'h0);
    end
    cyc(0, 16'h0, 0, 16'h0, 0);
    chk("sq3_fetch_instr", 32'(instr1), 32'h1030);
    chk("sq3_fetch_padd", 32'(padd1), 32'h31);
    cyc(1, 16'h50, 0, 16'h0, 0);
    cyc(0, 16'h0, 0, 16'h0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_pc", 32'(imem_addr1), 32'hFFFF);
    chk("async_rst_padd", 32'(padd1), 32'h0);
    chk("async_rst_valid", 32'(valid1), 32'h0);
    chk("async_rst_pc0", 32'(imem_addr0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 16'h0, 0, 16'h0, 0);
    chk("post_rst_instr", 32'(instr1), 32'h10FF);
    chk("post_rst_valid", 32'(valid1), 32'h1);
    chk("post_rst_instr0", 32'(instr0), 32'h1000);

    // Randomized run against the reference model
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 9) == 0), 16'($urandom), ($urandom_range(0, 19) == 0),
          16'($urandom), ($urandom_range(0, 4) == 0));
      chk("rnd_instr0", 32'(instr0), 32'(m_instr[0]));
      chk("rnd_padd0", 32'(padd0), 32'(m_padd[0]));
      chk("rnd_valid0", 32'(valid0), 32'(m_valid[0]));
      chk("rnd_halted0", 32'(halted0), 32'(m_halt[0]));
      chk("rnd_pc0", 32'(imem_addr0), 32'(m_pc[0]));
      chk("rnd_instr1", 32'(instr1), 32'(m_instr[1]));
      chk("rnd_padd1", 32'(padd1), 32'(m_padd[1]));
      chk("rnd_valid1", 32'(valid1), 32'(m_valid[1]));
      chk("rnd_halted1", 32'(halted1), 32'(m_halt[1]));
      chk("rnd_pc1", 32'(imem_addr1), 32'(m_pc[1]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
